// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU_sel codes, FSM state encoding, shift kinds and width defaults for alu_exec and the ALU control decoder
package alu_pkg;
  localparam int ALU_XLEN = 32;
  localparam int ALU_SHW = $clog2(ALU_XLEN);
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL_I = 4'd7;
  localparam logic [3:0] ALU_SRL_I = 4'd8;
  localparam logic [3:0] ALU_SRA_I = 4'd9;
  localparam logic [3:0] ALU_SLL_R = 4'd10;
  localparam logic [3:0] ALU_SRL_R = 4'd11;
  localparam logic [3:0] ALU_SRA_R = 4'd12;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;
  function automatic logic is_shift(input logic [3:0] sel);
    return sel >= ALU_SLL_I && sel <= ALU_SRA_R;
  endfunction
  function automatic logic [1:0] shift_kind(input logic [3:0] sel);
    return (sel == ALU_SLL_I || sel == ALU_SLL_R) ? SH_SLL :
           (sel == ALU_SRL_I || sel == ALU_SRL_R) ? SH_SRL : SH_SRA;
  endfunction
endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: operand/result handshake bundle; master = ID/EX producer plus writeback consumer, slave = alu_exec
interface alu_exec_if #(parameter int XLEN = 32);
  logic in_valid;
  logic in_ready;
  logic [3:0] alu_sel;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] result;
  logic zero;
  logic busy;
  modport master(output in_valid, alu_sel, a, b, out_ready, input in_ready, out_valid, result, zero, busy);
  modport slave(input in_valid, alu_sel, a, b, out_ready, output in_ready, out_valid, result, zero, busy);
endinterface

// File: rtl/alu_shift_step.sv
// alu_shift_step: combinational one-bit shifter (d in, q out; kind selects SLL/SRL/SRA)
module alu_shift_step import alu_pkg::*; #(
  parameter int XLEN = ALU_XLEN
) (
  input  logic [XLEN-1:0] d,
  input  logic [1:0]      kind,
  output logic [XLEN-1:0] q
);
  always_comb
    q = kind == SH_SLL ? {d[XLEN-2:0], 1'b0} :
        kind == SH_SRL ? {1'b0, d[XLEN-1:1]} : {d[XLEN-1], d[XLEN-1:1]};
endmodule

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle execute unit (clk, rst_n async low, bus slave: in handshake with alu_sel/a/b, out handshake with result/zero, busy)
module alu_exec import alu_pkg::*; #(
  parameter int XLEN = ALU_XLEN,
  parameter int SHW = $clog2(XLEN)
) (
  input logic      clk,
  input logic      rst_n,
  alu_exec_if.slave bus
);
  logic [1:0] state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic zero_q, zero_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [1:0] kind_q, kind_d;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] alu_val;
  logic [SHW-1:0] shamt;
  alu_shift_step #(.XLEN(XLEN)) u_step (.d(work_q), .kind(kind_q), .q(step));
  assign shamt = bus.b[SHW-1:0];
  always_comb
    alu_val = bus.alu_sel == ALU_AND  ? bus.a & bus.b :
              bus.alu_sel == ALU_OR   ? bus.a | bus.b :
              bus.alu_sel == ALU_XOR  ? bus.a ^ bus.b :
              bus.alu_sel == ALU_ADD  ? bus.a + bus.b :
              bus.alu_sel == ALU_SUB  ? bus.a - bus.b :
              bus.alu_sel == ALU_SLT  ? XLEN'($signed(bus.a) < $signed(bus.b)) :
              bus.alu_sel == ALU_SLTU ? XLEN'(bus.a < bus.b) :
              is_shift(bus.alu_sel)   ? bus.a : '0;
  // zero tracks the value loaded into result, so it is derived from result_d
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    work_d = work_q;
    cnt_d = cnt_q;
    kind_d = kind_q;
    if (state_q == ST_IDLE && bus.in_valid) begin
      if (is_shift(bus.alu_sel) && shamt != '0) begin
        work_d = bus.a;
        cnt_d = shamt;
        kind_d = shift_kind(bus.alu_sel);
        state_d = ST_SHIFT;
      end else begin
        result_d = alu_val;
        state_d = ST_DONE;
      end
    end else if (state_q == ST_SHIFT) begin
      work_d = step;
      cnt_d = cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) begin
        result_d = step;
        state_d = ST_DONE;
      end
    end else if (state_q == ST_DONE && bus.out_ready) begin
      state_d = ST_IDLE;
    end
    zero_d = result_d == '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      result_q <= '0;
      zero_q <= 1'b1;
      work_q <= '0;
      cnt_q <= '0;
      kind_q <= SH_SLL;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      zero_q <= zero_d;
      work_q <= work_d;
      cnt_q <= cnt_d;
      kind_q <= kind_d;
    end
  assign bus.in_ready = state_q == ST_IDLE;
  assign bus.out_valid = state_q == ST_DONE;
  assign bus.busy = state_q != ST_IDLE;
  assign bus.result = result_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and random checks of alu_exec against an arithmetic reference model
module tb_alu_exec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  alu_exec_if #(.XLEN(32)) bus();
  alu_exec dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_res(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (sel)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a ^ b;
      4'd3: return a + b;
      4'd4: return a - b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7, 4'd10: return a << sh;
      4'd8, 4'd11: return a >> sh;
      4'd9, 4'd12: return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction
  function automatic int ref_lat(input logic [3:0] sel, input logic [31:0] b);
    return (sel >= 4'd7 && sel <= 4'd12) ? 1 + int'(b[4:0]) : 1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic [3:0] sel, input logic [31:0] ai, input logic [31:0] bi, input int hold);
    logic [31:0] er;
    int el;
    int lat;
    er = ref_res(sel, ai, bi);
    el = ref_lat(sel, bi);
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.alu_sel = sel;
    bus.a = ai;
    bus.b = bi;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.alu_sel = 4'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      chk("busy_shift", 32'(bus.busy), 32'd1);
      chk("in_ready_shift", 32'(bus.in_ready), 32'd0);
      bus.in_valid = lat == 2;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(el));
    chk("result", bus.result, er);
    chk("zero", 32'(bus.zero), 32'(er == 32'd0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_result", bus.result, er);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("ack_valid", 32'(bus.out_valid), 32'd0);
    chk("ack_in_ready", 32'(bus.in_ready), 32'd1);
    chk("ack_busy", 32'(bus.busy), 32'd0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_sel = 4'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    #12;
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    do_op(4'd4, 32'd5, 32'd7, 0);
    do_op(4'd3, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'd5, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'd6, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    do_op(4'd12, 32'h8000_0000, 32'h24, 0);
    do_op(4'd7, 32'd1, 32'd31, 0);
    do_op(4'd11, 32'h8000_0000, 32'd0, 0);
    do_op(4'd8, 32'hDEAD_BEEF, 32'h20, 0);
    do_op(4'd9, 32'h8765_4321, 32'd31, 0);
    do_op(4'd2, 32'hF0F0_F0F0, 32'hFFFF_0000, 10);
    for (int i = 0; i < 30; i++)
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 2)));
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_sel = 4'd7;
    bus.a = $urandom | 32'd1;
    bus.b = 32'd20;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_result", bus.result, 32'd0);
    chk("async_zero", 32'(bus.zero), 32'd1);
    chk("async_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'd3, 32'd2, 32'd3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
